// File: rtl/cordic_vector.sv
// rtl/cordic_vector.sv - iterative 21-bit vectoring-mode CORDIC (atan2 and K-scaled magnitude)
module cordic_vector (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic signed [20:0] x_in,
  input  logic signed [20:0] y_in,
  output logic               busy,
  output logic               done,
  output logic        [20:0] mag_out,
  output logic signed [20:0] angle_out
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic signed [20:0] PI = 21'sd823550;

  state_t             state;
  logic        [3:0]  i;
  logic signed [20:0] x;
  logic signed [20:0] y;
  logic signed [20:0] z;
  logic               zero_flag;
  logic signed [20:0] x_sh;
  logic signed [20:0] y_sh;
  logic signed [20:0] atan_val;

  // round(atan(2^-i) * 2^18)
  always_comb begin
    atan_val = '0;
    case (i)
      4'd0:  atan_val = 21'sd205887;
      4'd1:  atan_val = 21'sd121542;
      4'd2:  atan_val = 21'sd64220;
      4'd3:  atan_val = 21'sd32599;
      4'd4:  atan_val = 21'sd16363;
      4'd5:  atan_val = 21'sd8189;
      4'd6:  atan_val = 21'sd4096;
      4'd7:  atan_val = 21'sd2048;
      4'd8:  atan_val = 21'sd1024;
      4'd9:  atan_val = 21'sd512;
      4'd10: atan_val = 21'sd256;
      4'd11: atan_val = 21'sd128;
      4'd12: atan_val = 21'sd64;
      4'd13: atan_val = 21'sd32;
      4'd14: atan_val = 21'sd16;
      4'd15: atan_val = 21'sd8;
      default: atan_val = '0;
    endcase
  end

  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      zero_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mag_out   <= '0;
      angle_out <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Fold left-half-plane vectors into the right half so the iterations converge
            if (!x_in[20]) begin
              x <= x_in;
              y <= y_in;
              z <= '0;
            end else begin
              x <= -x_in;
              y <= -y_in;
              z <= y_in[20] ? -PI : PI;
            end
            zero_flag <= (x_in == '0) && (y_in == '0);
            i         <= '0;
            busy      <= 1'b1;
            state     <= ITER;
          end
        end
        ITER: begin
          if (!y[20]) begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_val;
          end else begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_val;
          end
          i <= i + 4'd1;
          if (i == 4'd15) state <= DONE;
        end
        DONE: begin
          mag_out   <= x;
          angle_out <= zero_flag ? 21'sd0 : z;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// tb/tb_cordic_vector.sv - directed self-checking bench for cordic_vector
module tb_cordic_vector;

  logic               clk;
  logic               reset;
  logic               clk_en;
  logic               start;
  logic signed [20:0] x_in;
  logic signed [20:0] y_in;
  logic               busy;
  logic               done;
  logic        [20:0] mag;
  logic signed [20:0] angle;

  int checks = 0;
  int errors = 0;

  cordic_vector dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .mag_out   (mag),
    .angle_out (angle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (((obs >= exp - 16) && (obs <= exp + 16)) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-16", tag, obs, exp);
    end
  endtask

  // Pulse start, then count enabled edges until done rises (bounded).
  task automatic run_op(input logic signed [20:0] xv, input logic signed [20:0] yv,
                        output int lat, output logic busy_after);
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_after = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dones;
    int done_at;
    logic b;
    logic signed [31:0] a;

    reset = 1'b1; clk_en = 1'b1; start = 1'b0; x_in = '0; y_in = '0;
    repeat (3) tick();
    check_eq("rst_busy",  32'(busy), 0);
    check_eq("rst_done",  32'(done), 0);
    check_eq("rst_mag",   32'(mag), 0);
    check_eq("rst_angle", 32'(angle), 0);
    reset = 1'b0;
    tick();

    run_op(21'sd131072, 21'sd0, lat, b);
    check_eq("busy_after_start", 32'(b), 1);
    check_eq("lat_x_axis", lat, 17);
    check_eq("busy_at_done", 32'(busy), 0);
    check_near("mag_x_axis", 32'(mag), 215845);
    check_near("ang_x_axis", 32'(angle), 0);
    tick();
    check_eq("done_one_cycle", 32'(done), 0);
    check_near("mag_hold", 32'(mag), 215845);

    run_op(21'sd0, 21'sd131072, lat, b);
    check_eq("lat_y_axis", lat, 17);
    check_near("ang_y_axis", 32'(angle), 411775);
    check_near("mag_y_axis", 32'(mag), 215845);
    tick();

    run_op(-21'sd131072, -21'sd131072, lat, b);
    check_near("ang_q3", 32'(angle), -617662);
    check_near("mag_q3", 32'(mag), 305249);
    tick();

    run_op(-21'sd131072, 21'sd131072, lat, b);
    check_near("ang_q2", 32'(angle), 617662);
    check_near("mag_q2", 32'(mag), 305249);
    tick();

    run_op(21'sd0, 21'sd0, lat, b);
    check_eq("mag_zero", 32'(mag), 0);
    check_eq("ang_zero", 32'(angle), 0);
    tick();

    run_op(-21'sd131072, 21'sd0, lat, b);
    a = 32'(angle);
    check_near("ang_pi_abs", (a < 0) ? -a : a, 823550);
    check_near("mag_neg_x", 32'(mag), 215845);
    tick();

    // Extra start pulses at N+5 and N+17 must be ignored.
    x_in = 21'sd131072; y_in = 21'sd131072; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0; done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      start = (k == 5 || k == 17);
      x_in  = start ? -21'sd131072 : 21'sd131072;
      y_in  = start ? -21'sd131072 : 21'sd131072;
      tick();
      if (done === 1'b1) begin
        dones++;
        if (done_at < 0) begin
          done_at = k;
          check_near("ign_ang", 32'(angle), 205887);
          check_near("ign_mag", 32'(mag), 305249);
        end
      end
    end
    start = 1'b0;
    check_eq("ign_done_count", dones, 1);
    check_eq("ign_done_edge", done_at, 17);
    check_eq("ign_busy_idle", 32'(busy), 0);

    // clk_en low for 10 edges mid-ITER delays done by exactly 10.
    x_in = 21'sd0; y_in = 21'sd131072; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 80) begin
      clk_en = (lat >= 5 && lat < 15) ? 1'b0 : 1'b1;
      tick();
      lat++;
    end
    check_eq("stall_lat", lat, 27);
    check_near("stall_ang", 32'(angle), 411775);
    check_near("stall_mag", 32'(mag), 215845);
    clk_en = 1'b0;
    repeat (2) tick();
    check_eq("stall_done_held", 32'(done), 1);
    clk_en = 1'b1;
    tick();
    check_eq("stall_done_clr", 32'(done), 0);

    // Reset at N+8 aborts the operation.
    x_in = 21'sd131072; y_in = 21'sd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy",  32'(busy), 0);
    check_eq("abort_done",  32'(done), 0);
    check_eq("abort_mag",   32'(mag), 0);
    check_eq("abort_angle", 32'(angle), 0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check_eq("abort_no_done", dones, 0);

    run_op(21'sd0, 21'sd131072, lat, b);
    check_eq("post_abort_lat", lat, 17);
    check_near("post_abort_ang", 32'(angle), 411775);
    check_near("post_abort_mag", 32'(mag), 215845);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_vector.md
# cordic_vector

Iterative 21-bit CORDIC engine in vectoring mode: the inverse of the rotation-mode datapath used by the cosine accelerator. Given a Cartesian vector (x, y), it drives y to zero over 16 micro-rotations and returns the angle atan2(y, x) and the CORDIC-gain-scaled magnitude. It sits beside the rotation engine as a start/done custom-instruction-style unit, with a single shared adder set reused across iterations.

## Interface
- No parameters. Word length is fixed at 21 bits and the iteration count is fixed at 16.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  when low, all registers hold (FSM, counter, datapath, outputs).
- start  in  1  one-cycle request; sampled only in IDLE with clk_en=1.
- x_in  in  21  signed Q3.18; |x_in| < 1.0 (262144) required.
- y_in  in  21  signed Q3.18; |y_in| < 1.0 required.
- busy  out  1  high from the load edge until done is raised.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- mag_out  out  21  unsigned-valued Q3.18 magnitude × K (K ≈ 1.646760), not gain-corrected.
- angle_out  out  21  signed Q3.18 radians, in [-π, π].

## Operation
- FSM states: IDLE, ITER, DONE.
- IDLE + start: load the registers and go to ITER with the counter i=0.
  - Pre-rotation applied on load:
    - x_in ≥ 0: x=x_in, y=y_in, z=0.
    - x_in < 0 and y_in ≥ 0: x=-x_in, y=-y_in, z=+PI.
    - x_in < 0 and y_in < 0: x=-x_in, y=-y_in, z=-PI.
  - PI = 823550, which is round(π·2^18).
  - Latch zero_flag = (x_in==0 && y_in==0).
- ITER, per cycle, using values from the same register set:
  - y[20]==0: x ← x + (y>>>i), y ← y − (x>>>i), z ← z + ATAN[i].
  - y[20]==1: x ← x − (y>>>i), y ← y + (x>>>i), z ← z − ATAN[i].
  - Both shifts are arithmetic. Arithmetic is 21-bit wrap, with no saturation; the input range guarantees no overflow.
  - ATAN[i] = round(atan(2^-i)·2^18), i=0..15, held in a constant ROM. ATAN[0]=205887.
  - Increment i. After the i=15 iteration, go to DONE.
- DONE:
  - mag_out ← x.
  - angle_out ← zero_flag ? 0 : z.
  - Raise done for one cycle, clear busy, return to IDLE.
- start is ignored while busy. A start arriving in the DONE cycle is also ignored.
- mag_out and angle_out hold their values until the next DONE.

## Timing
- Reset values: busy=0, done=0, mag_out=0, angle_out=0, state=IDLE, i=0.
- Cycle timeline, counting only clk_en=1 edges:
  - Start is sampled at edge N.
  - Iterations occur at edges N+1..N+16.
  - Outputs are registered and done goes to 1 at edge N+17.
  - done returns to 0 at edge N+18.
- Latency is 17 enabled cycles. Throughput is one operation per 18 enabled cycles; the earliest next start is sampled at edge N+18.
- clk_en=0 stretches every phase, including holding done high until the next enabled edge.
- Reset mid-operation: aborts the operation, no done is produced, and outputs return to 0. Reset wins over start and clk_en.
- Accuracy: angle error ≤ 16 LSB and magnitude error ≤ 16 LSB against ideal values × K.

## Test plan
- x_in=131072, y_in=0 → done at start+17 enabled cycles; mag_out≈215845 (±16), angle_out≈0 (±16).
- x_in=0, y_in=131072 → angle_out≈411775 (π/2, ±16), mag_out≈215845.
- x_in=-131072, y_in=-131072 → angle_out≈-617662 (−3π/4, ±16), mag_out≈305249 (±16). Repeat with y_in=+131072 → +617662.
- x_in=0, y_in=0 → mag_out=0, angle_out=0 exactly. Then x_in=-131072, y_in=0 → |angle_out|≈823550 (±16).
- Pulse start again at cycles N+5 and N+17 during an operation → the start pulses are ignored, exactly one done appears, and the outputs match the first operands. Drop clk_en for 10 cycles mid-ITER → done is delayed by exactly 10 cycles and the results are unchanged.
- Assert reset at N+8 → busy=0, done never pulses, mag_out=angle_out=0. A subsequent start completes normally.
